// File: rtl/hit_tally.sv
// hit_tally: two-digit BCD event tally with a stretched hit LED and
// seven-segment decode of both digits.
// Optional build macro HIT_TALLY_SAT_EN: the tally holds at 99 instead of
// wrapping to 00.
//
//  state | meaning
//  IDLE  | no recent hit, led low
//  HOLD  | hit seen within the last STRETCH cycles, led high
module hit_tally #(
    parameter int unsigned STRETCH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       clear,
    output logic [3:0] count_ones,
    output logic [3:0] count_tens,
    output logic       led,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The counter runs STRETCH-1 down to 0, and HOLD takes one more edge to
    // leave, so led stays high for STRETCH cycles.
    localparam logic [3:0] RELOAD = 4'(STRETCH - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       led_q, led_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // Active-low segment pattern, bit 0 = a ... bit 6 = g; non-BCD input blanks.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Stretch FSM next state: a hit always (re)loads the hold counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = HOLD;
                    hold_d  = RELOAD;
                end
            end
            HOLD: begin
                if (hit) begin
                    hold_d = RELOAD;
                end else if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 4'd0;
            end
        endcase
        led_d = (state_d == HOLD);
    end

    // BCD tally next value; clear wins over hit and leaves the FSM alone.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (hit) begin
            if (ones_q == 4'd9) begin
                if (tens_q == 4'd9) begin
`ifdef HIT_TALLY_SAT_EN
                    ones_d = 4'd9;
                    tens_d = 4'd9;
`else
                    ones_d = 4'd0;
                    tens_d = 4'd0;
`endif
                end else begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // State registers with synchronous reset overriding hit and clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 4'd0;
            led_q   <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
        end
    end

    // Output decode; the tens digit is blanked when it is a leading zero.
    always_comb begin
        count_ones = ones_q;
        count_tens = tens_q;
        led        = led_q;
        HEX0       = seg7(ones_q);
        HEX1       = (tens_q == 4'd0) ? 7'b1111111 : seg7(tens_q);
    end

endmodule

// File: tb/tb_hit_tally.sv
// Testbench for hit_tally: directed vector table, hand-written wrap/saturation
// sequence, and randomized stimulus against an arithmetic reference model.
module tb_hit_tally;

    localparam int unsigned STRETCH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hit = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] count_ones;
    logic [3:0] count_tens;
    logic       led;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    int checks = 0;
    int errors = 0;

    // Reference model: tally as an integer, led from edges since last hit.
    int m_tally = 0;
    int m_since = 1000;

    logic [6:0] seg_tab [10];

    hit_tally #(.STRETCH(STRETCH)) dut (
        .clk        (clk),
        .reset      (reset),
        .hit        (hit),
        .clear      (clear),
        .count_ones (count_ones),
        .count_tens (count_tens),
        .led        (led),
        .HEX0       (HEX0),
        .HEX1       (HEX1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic h;
        logic c;
        int   ones;
        int   tens;
        logic l;
    } vec_t;

    vec_t vecs [35];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, sample outputs #1 after the edge.
    task automatic step(input logic r, input logic h, input logic c);
        reset = r;
        hit   = h;
        clear = c;
        @(posedge clk);
        if (r) begin
            m_tally = 0;
            m_since = 1000;
        end else begin
            if (c) m_tally = 0;
            else if (h) begin
`ifdef HIT_TALLY_SAT_EN
                m_tally = (m_tally == 99) ? 99 : m_tally + 1;
`else
                m_tally = (m_tally + 1) % 100;
`endif
            end
            if (h) m_since = 0;
            else if (m_since < 1000) m_since++;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        int o;
        int t;
        logic [6:0] h1;
        o  = m_tally % 10;
        t  = m_tally / 10;
        h1 = (t == 0) ? 7'b1111111 : seg_tab[t];
        chk({tag, ".ones"}, 8'(count_ones), 8'(o));
        chk({tag, ".tens"}, 8'(count_tens), 8'(t));
        chk({tag, ".led"},  8'(led), 8'(m_since < int'(STRETCH)));
        chk({tag, ".hex0"}, 8'(HEX0), 8'(seg_tab[o]));
        chk({tag, ".hex1"}, 8'(HEX1), 8'(h1));
    endtask

    function automatic vec_t mk(logic r, logic h, logic c, int o, int t, logic l);
        vec_t v;
        v.r = r; v.h = h; v.c = c; v.ones = o; v.tens = t; v.l = l;
        return v;
    endfunction

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        // {reset, hit, clear, ones, tens, led} expected after each edge
        vecs[0]  = mk(1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 1, 0, 1);   // single hit
        vecs[6]  = mk(0, 0, 0, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 1, 0, 1);
        vecs[9]  = mk(0, 0, 0, 1, 0, 0);   // exactly 4 cycles of led
        vecs[10] = mk(0, 0, 0, 1, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 0);   // clear alone
        vecs[12] = mk(0, 1, 0, 1, 0, 1);   // three back-to-back hits
        vecs[13] = mk(0, 1, 0, 2, 0, 1);
        vecs[14] = mk(0, 1, 0, 3, 0, 1);
        vecs[15] = mk(0, 0, 0, 3, 0, 1);
        vecs[16] = mk(0, 0, 0, 3, 0, 1);
        vecs[17] = mk(0, 0, 0, 3, 0, 1);
        vecs[18] = mk(0, 0, 0, 3, 0, 0);
        vecs[19] = mk(0, 1, 0, 4, 0, 1);
        vecs[20] = mk(0, 1, 0, 5, 0, 1);
        vecs[21] = mk(0, 1, 0, 6, 0, 1);
        vecs[22] = mk(0, 1, 0, 7, 0, 1);
        vecs[23] = mk(0, 0, 0, 7, 0, 1);
        vecs[24] = mk(0, 0, 0, 7, 0, 1);
        vecs[25] = mk(0, 0, 0, 7, 0, 1);
        vecs[26] = mk(0, 0, 0, 7, 0, 0);
        vecs[27] = mk(0, 1, 1, 0, 0, 1);   // hit+clear at 07: tally 00, led holds
        vecs[28] = mk(0, 0, 0, 0, 0, 1);
        vecs[29] = mk(1, 0, 0, 0, 0, 0);   // reset mid-HOLD
        vecs[30] = mk(0, 1, 0, 1, 0, 1);   // full restart of the hold
        vecs[31] = mk(0, 0, 0, 1, 0, 1);
        vecs[32] = mk(0, 0, 0, 1, 0, 1);
        vecs[33] = mk(0, 0, 0, 1, 0, 1);
        vecs[34] = mk(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 35; i++) begin
            logic [6:0] e0;
            step(vecs[i].r, vecs[i].h, vecs[i].c);
            e0 = seg_tab[vecs[i].ones];
            chk($sformatf("vec%0d.ones", i), 8'(count_ones), 8'(vecs[i].ones));
            chk($sformatf("vec%0d.tens", i), 8'(count_tens), 8'(vecs[i].tens));
            chk($sformatf("vec%0d.led", i),  8'(led), 8'(vecs[i].l));
            chk($sformatf("vec%0d.hex0", i), 8'(HEX0), 8'(e0));
            chk($sformatf("vec%0d.hex1", i), 8'(HEX1), 8'h7F);
        end

        // 100 spaced hits from 00: tens carry, 99, then wrap or saturate.
        step(1, 0, 0);
        chk_model("rst100");
        for (int n = 1; n <= 100; n++) begin
            step(0, 1, 0);
            step(0, 0, 0);
            chk_model($sformatf("hit%0d", n));
            if (n == 10) begin
                chk("ten.hex1", 8'(HEX1), 8'(7'b1111001));
                chk("ten.hex0", 8'(HEX0), 8'(7'b1000000));
            end
            if (n == 99) begin
                chk("n99.ones", 8'(count_ones), 8'd9);
                chk("n99.tens", 8'(count_tens), 8'd9);
                chk("n99.hex1", 8'(HEX1), 8'(7'b0010000));
            end
            if (n == 100) begin
`ifdef HIT_TALLY_SAT_EN
                chk("n100.ones", 8'(count_ones), 8'd9);
                chk("n100.tens", 8'(count_tens), 8'd9);
`else
                chk("n100.ones", 8'(count_ones), 8'd0);
                chk("n100.tens", 8'(count_tens), 8'd0);
                chk("n100.hex1", 8'(HEX1), 8'h7F);
`endif
            end
        end

        // Randomized traffic against the model.
        step(1, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic h;
            logic c;
            int   p;
            p = int'($urandom_range(0, 99));
            h = ((i / 200) % 2 == 0) ? (p < 45) : (p < 12);
            c = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 199) == 0);
            step(r, h, c);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/hit_tally.md
HIT_TALLY -- requirements
Module: hit_tally

Interface
REQ-001 The module SHALL have parameter STRETCH, default 4, the number of cycles led stays high after the last hit (legal range 1..15).
REQ-002 The module SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The module SHALL have port hit  input  1  detection pulse from the upstream pattern recognizer; each cycle sampled high is one event.
REQ-005 The module SHALL have port clear  input  1  synchronous count clear, active-high.
REQ-006 The module SHALL have port count_ones  output  4  BCD ones digit of the event tally, 0..9.
REQ-007 The module SHALL have port count_tens  output  4  BCD tens digit of the event tally, 0..9.
REQ-008 The module SHALL have port led  output  1  registered, stretched hit indicator.
REQ-009 The module SHALL have port HEX0  output  7  active-low seven-segment code for count_ones, bit 0 = segment a through bit 6 = segment g.
REQ-010 The module SHALL have port HEX1  output  7  active-low seven-segment code for count_tens, same bit order.

Function
REQ-011 The tally SHALL be a two-digit BCD counter, 00..99; ones wraps 9->0 with tens incremented in the same edge.
REQ-012 The tally SHALL increment exactly once per rising edge at which hit=1 and clear=0; back-to-back hit cycles each count.
REQ-013 Latency SHALL be one cycle: hit sampled at edge k gives updated count_ones/count_tens after edge k.
REQ-014 When clear=1 at an edge, the tally SHALL become 00 regardless of hit; clear SHALL NOT affect led or the stretch FSM.
REQ-015 The led FSM SHALL have states IDLE (led=0) and HOLD (led=1), with a 4-bit hold counter.
REQ-016 In IDLE with hit=1, next state SHALL be HOLD and the hold counter SHALL load STRETCH-1.
REQ-017 In HOLD with hit=1, the state SHALL stay HOLD and the hold counter SHALL reload STRETCH-1 (retrigger).
REQ-018 In HOLD with hit=0, the hold counter SHALL decrement when nonzero; when it is zero the state SHALL return to IDLE.
REQ-019 An isolated one-cycle hit SHALL therefore produce led=1 for exactly STRETCH consecutive cycles, starting the cycle after the sampling edge.
REQ-020 HEX0 SHALL combinationally decode count_ones (0..9).
REQ-021 HEX1 SHALL decode count_tens, except it SHALL be blank (7'b1111111) when count_tens=0 (leading-zero blanking).

Reset
REQ-022 With reset=1 at an edge, the tally SHALL become 00, the FSM IDLE, the hold counter 0, and led 0; reset SHALL override hit and clear.
REQ-023 After reset, HEX0 SHALL show "0" (7'b1000000) and HEX1 SHALL be blank.
REQ-024 Reset asserted mid-HOLD SHALL drop led to 0 after that edge, with no residual stretch.

Configuration
REQ-025 With macro HIT_TALLY_SAT_EN defined, the tally SHALL saturate at 99: a hit at 99 leaves 99.
REQ-026 Without HIT_TALLY_SAT_EN, a hit at 99 SHALL wrap the tally to 00.

Verification
REQ-027 Reset for 1 cycle, then hit=0 for 4 cycles -> count 00, led 0, HEX0=1000000, HEX1=1111111 throughout.
REQ-028 Single 1-cycle hit with STRETCH=4 -> count_ones=1 after that edge; led high exactly 4 cycles, then 0.
REQ-029 hit high 3 consecutive cycles, then low -> count 03; led high continuously until 4 cycles after the last hit.
REQ-030 Apply 100 single hits from 00 -> reads 99 after 99 hits with HEX1=0010000 (9); the 100th hit gives 99 with HIT_TALLY_SAT_EN and 00 without it.
REQ-031 hit=1 and clear=1 at the same edge with tally 07 -> tally 00, led still enters HOLD.
REQ-032 Assert reset 2 cycles into a HOLD period -> led 0 and tally 00 after that edge; a subsequent hit restarts a full STRETCH-cycle hold.
